// File: rtl/block_signaling.sv
// Automatic four-aspect block-signalling controller for NUM_BLOCKS consecutive sections.
// Synchronised occupancy/fault inputs drive per-section state machines with a release hold timer.
module block_signaling #(
  parameter int unsigned NUM_BLOCKS  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned HOLD_W      = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NUM_BLOCKS-1:0]   occ,
  input  logic                    exit_occ,
  input  logic [NUM_BLOCKS-1:0]   fault,
  input  logic                    fault_clr,
  output logic [2*NUM_BLOCKS-1:0] aspect,
  output logic [NUM_BLOCKS-1:0]   fault_vec,
  output logic                    fault_any
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_OCCUPIED,
    S_RELEASING,
    S_FAULT
  } sec_state_t;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [NUM_BLOCKS-1:0] occ_s1, occ_s2;
  logic [NUM_BLOCKS-1:0] flt_s1, flt_s2;
  logic                  exit_s1, exit_s2;

  sec_state_t        state_q [NUM_BLOCKS];
  sec_state_t        state_d [NUM_BLOCKS];
  logic [HOLD_W-1:0] cnt_q   [NUM_BLOCKS];
  logic [HOLD_W-1:0] cnt_d   [NUM_BLOCKS];

  logic [NUM_BLOCKS+1:0]   e;
  logic [2*NUM_BLOCKS-1:0] aspect_d;
  logic [NUM_BLOCKS-1:0]   fault_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      occ_s1  <= '0;
      occ_s2  <= '0;
      flt_s1  <= '0;
      flt_s2  <= '0;
      exit_s1 <= 1'b0;
      exit_s2 <= 1'b0;
    end else begin
      occ_s1  <= occ;
      occ_s2  <= occ_s1;
      flt_s1  <= fault;
      flt_s2  <= flt_s1;
      exit_s1 <= exit_occ;
      exit_s2 <= exit_s1;
    end
  end

  // Reset is fail-safe: every section holds protected for a full release period.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        state_q[i] <= S_RELEASING;
        cnt_q[i]   <= HOLD_LOAD;
      end
      aspect    <= '0;
      fault_vec <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      aspect    <= aspect_d;
      fault_vec <= fault_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (flt_s2[i]) begin
        state_d[i] = S_FAULT;
      end else begin
        unique case (state_q[i])
          S_CLEAR: begin
            if (occ_s2[i]) state_d[i] = S_OCCUPIED;
          end
          S_OCCUPIED: begin
            if (!occ_s2[i]) begin
              state_d[i] = S_RELEASING;
              cnt_d[i]   = HOLD_LOAD;
            end
          end
          S_RELEASING: begin
            if (occ_s2[i])              state_d[i] = S_OCCUPIED;
            else if (cnt_q[i] != '0)    cnt_d[i]   = cnt_q[i] - HOLD_W'(1);
            else                        state_d[i] = S_CLEAR;
          end
          S_FAULT: begin
            // Fault input is known low here, so an acknowledge is always honoured.
            if (fault_clr) begin
              state_d[i] = S_RELEASING;
              cnt_d[i]   = HOLD_LOAD;
            end
          end
          default: state_d[i] = S_FAULT;
        endcase
      end
    end
  end

  always_comb begin
    e = '0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      e[i] = (state_q[i] != S_CLEAR);
    end
    e[NUM_BLOCKS]   = exit_s2;
    e[NUM_BLOCKS+1] = 1'b0;
  end

  always_comb begin
    aspect_d = '0;
    fault_d  = '0;
    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
      if (e[i])        aspect_d[2*i +: 2] = 2'b00;
      else if (e[i+1]) aspect_d[2*i +: 2] = 2'b01;
      else if (e[i+2]) aspect_d[2*i +: 2] = 2'b10;
      else             aspect_d[2*i +: 2] = 2'b11;
      fault_d[i] = (state_q[i] == S_FAULT);
    end
  end

  assign fault_any = |fault_vec;

endmodule

// File: doc/block_signaling.md
# block_signaling

Parametrised automatic block-signalling controller for a line of `NUM_BLOCKS` consecutive track sections. It drives one four-aspect signal per section from synchronised track-circuit occupancy and fault inputs. It adds a release hold timer, latched fault protection, and an exit-block input. It sits between the track-circuit interface and the lamp drivers, and replaces the fixed four-signal single-sensor controller.

## Interface
- `NUM_BLOCKS`, default 4: number of sections and signals; must be ≥ 2.
- `HOLD_CYCLES`, default 8: cycles a section stays protected after it clears; must be ≥ 1.
- `HOLD_W`, default 8: width of each hold counter; must satisfy `HOLD_CYCLES` ≤ 2^`HOLD_W`.
- `clk`, input, 1: the single clock; all state is updated on its rising edge.
- `clr`, input, 1: asynchronous, active-high reset.
- `occ`, input, `NUM_BLOCKS`: track-circuit occupancy; bit i is section i; asynchronous.
- `exit_occ`, input, 1: occupancy of the section beyond the last block; asynchronous.
- `fault`, input, `NUM_BLOCKS`: track-circuit or lamp fault per section; asynchronous.
- `fault_clr`, input, 1: synchronous single-cycle acknowledge for latched faults.
- `aspect`, output, 2×`NUM_BLOCKS`: bits [2i+1:2i] hold the aspect of signal i; registered.
- `fault_vec`, output, `NUM_BLOCKS`: latched fault flag per section; registered.
- `fault_any`, output, 1: OR of `fault_vec`.

## Operation
- Direction of travel is block 0 → block `NUM_BLOCKS-1` → exit. Signal i guards entry to section i.
- Aspect encoding: 00 red, 01 single yellow, 10 double yellow, 11 green.
- Input conditioning: `occ`, `fault` and `exit_occ` each pass through a 2-flop synchroniser. The synchroniser flops reset to 0. `fault_clr` is not synchronised.
- Each section has a state machine with states CLEAR, OCCUPIED, RELEASING and FAULT, plus a `HOLD_W`-bit counter.
  - Any state, synchronised fault high → FAULT. This takes priority over all other transitions.
  - CLEAR, occupancy high → OCCUPIED.
  - OCCUPIED, occupancy low → RELEASING, counter loaded with `HOLD_CYCLES-1`.
  - RELEASING, occupancy high → OCCUPIED.
  - RELEASING, counter ≠ 0 → decrement the counter.
  - RELEASING, counter = 0 → CLEAR.
  - FAULT, `fault_clr`=1 and synchronised fault low → RELEASING, counter loaded with `HOLD_CYCLES-1`.
  - FAULT, `fault_clr`=1 while synchronised fault is still high → ignored; stays in FAULT.
- Effective occupancy `e[i]` is 1 in every state except CLEAR. Define `e[NUM_BLOCKS]` = synchronised `exit_occ` and `e[NUM_BLOCKS+1]` = 0.
- Aspect rule for signal i, registered:
  - `e[i]` → 00.
  - otherwise `e[i+1]` → 01.
  - otherwise `e[i+2]` → 10.
  - otherwise → 11.
- `fault_vec[i]` is 1 exactly while section i is in FAULT. `fault_any` is combinational from `fault_vec`.
- Reset, fail-safe:
  - All sections go to RELEASING with the counter at `HOLD_CYCLES-1`.
  - `aspect` = all 00, `fault_vec` = 0, `fault_any` = 0.
  - Asserting `clr` mid-operation forces all-red immediately, without waiting for a clock edge.

## Timing
- Occupancy onset: input first sampled high at edge E0 → sync stage 2 high at E1 → state OCCUPIED at E2 → `aspect` updated at E3, a latency of 3 edges.
- Occupancy release: input first sampled low at E0 → state RELEASING at E2 → CLEAR at E2+`HOLD_CYCLES` → `aspect` updated at E3+`HOLD_CYCLES`.
- After `clr` deasserts with all inputs low: CLEAR at the `HOLD_CYCLES`-th edge, all-green at the (`HOLD_CYCLES`+1)-th edge.
- Fault onset: same 3-edge latency as occupancy, to both `aspect` (red) and `fault_vec`.
- Fault clear: `fault_clr` sampled at edge F → RELEASING at F → CLEAR at F+`HOLD_CYCLES` → `aspect` updated at F+`HOLD_CYCLES`+1.
- Pulses shorter than one clock period on `occ` or `fault` may be missed. Upstream holds them for at least 2 cycles.
- Simultaneous events:
  - Fault and occupancy together → FAULT.
  - Re-occupancy on the same edge that the counter reaches 0 → OCCUPIED.

## Test plan
All scenarios use `NUM_BLOCKS`=4 and `HOLD_CYCLES`=8.
- Reset release: assert `clr`, then deassert with all inputs 0. Required: `aspect`=0x00 during reset and through 8 edges, then 0xFF at edge 9; `fault_any`=0 throughout.
- Single train: hold `occ`=4'b0100. Required: `aspect`=0xC6 (signals 3..0 = 11,00,01,10) 3 edges after the first high sample.
- Release hold: drop `occ[2]` to 0. Required: `aspect` stays 0xC6 for 10 edges and becomes 0xFF at edge E0+11.
- Re-occupancy mid-hold: drop `occ[2]` for 5 cycles, then raise it again. Required: `aspect` never leaves 0xC6.
- Fault latch: hold `fault[1]`=1 for 3 cycles, then release it. Required: `fault_vec`=4'b0010, `fault_any`=1, and `aspect`[3:2]=00 persisting. `fault_clr` pulsed while `fault[1]` is still high has no effect. `fault_clr` pulsed after the fault drops gives `fault_vec`=0 and `aspect`=0xFF 9 edges later.
- Exit block plus mid-run reset: `exit_occ`=1 with all sections clear. Required: `aspect`=0x6F. Then assert `clr` asynchronously between edges. Required: `aspect`=0x00 before the next edge.
